// File: rtl/fp_sub_result_packer.sv
// fp_sub_result_packer
//   Output stage of the combinational FP subtractor. On every accepted input
//   it attaches the result sign to the subtractor's 31-bit magnitude. Exact
//   cancellation and exponent underflow are forced to +0.0. The packed word
//   is buffered in a small FIFO and presented downstream over valid/ready.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
//   valid && ready are both high. in_ready depends only on the FIFO fill
//   level, never on out_ready. A full FIFO refuses a push even in a cycle
//   that also pops. out_data/out_zero hold steady while out_valid && !out_ready.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   upstream handshake
//   x0, y0              original operands (IEEE-754 single); only bits 30:0
//                       of y0 are used, because the sign comes from x0
//   r_mag               subtractor magnitude {exp[30:23], frac[22:0]}
//   out_valid/out_ready downstream handshake
//   out_data            packed {sign, exp, frac}; 0 when out_valid is low
//   out_zero            out_data was forced to +0.0
//   zero_cnt, flush_cnt saturating statistics counters
//
// Build option: define FP_PACK_STATS_EN to enable the statistics counters.
// When it is undefined the counters are tied to 0. The datapath and the
// handshake timing are the same in both builds.

module fp_sub_result_packer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      x0,
   input  logic [31:0]      y0,
   input  logic [30:0]      r_mag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic             out_zero,
   output logic [CNT_W-1:0] zero_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

   // Each entry is {zero_flag, packed_word}.
   logic [32:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   logic        push;
   logic        pop;
   logic        cancel;
   logic        flush;
   logic        sign;
   logic [32:0] packed_entry;

   // The y0 sign is not needed: the operands are assumed to share a sign,
   // and mixed-sign operands are resolved upstream.
   logic unused_y_sign;
   assign unused_y_sign = y0[31];

   always_comb begin
      cancel       = (x0[30:0] == y0[30:0]);
      flush        = !cancel && (r_mag[30:23] == 8'h00);
      // Same-sign subtraction flips the sign when |x| < |y|.
      sign         = x0[31] ^ (x0[30:0] < y0[30:0]);
      packed_entry = {1'b0, sign, r_mag};
      if (cancel || flush) begin
         packed_entry = {1'b1, 32'h0000_0000};
      end
   end

   assign in_ready  = (count < DEPTH_C);
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Reading is combinational from the head entry. A pushed word is therefore
   // visible right after the edge that wrote it.
   assign out_data  = out_valid ? mem[rd_ptr][31:0] : 32'h0000_0000;
   assign out_zero  = out_valid ? mem[rd_ptr][32]   : 1'b0;

   // Storage is not reset. It is never observed while count == 0.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= packed_entry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

`ifdef FP_PACK_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_cnt  <= '0;
         flush_cnt <= '0;
      end else begin
         if (push && cancel && (zero_cnt != '1)) begin
            zero_cnt <= zero_cnt + CNT_W'(1);
         end
         if (push && flush && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end
`else
   assign zero_cnt  = '0;
   assign flush_cnt = '0;
`endif

endmodule
